ota_pdm_out: RTL
================

// Module: ota_pdm_out
// PURPOSE
//  Output stage directly downstream of the digital OTA core in tt_um_digiOTA_an.
//  Takes signed 8-bit transconductance codes from the core through a valid/ready
//  handshake and holds each code for HOLD_CYC clocks. During that window it turns
//  the code into a first-order pulse-density stream on two charge-pump pins
//  (out_up / out_dn) that drive the external RC load.
// PARAMETERS
//  W         8   code width; signed two's complement
//  HOLD_CYC  16  clocks each accepted code is applied; must be >= 2
//  DEAD_CYC  2   non-overlap clocks on a direction change; used only with OTA_DEADTIME_EN
// PORTS
//  clk       in   1  single system clock; all logic on the rising edge
//  rst_n     in   1  reset; synchronous, active-low
//  ena       in   1  design enable; low = freeze
//  in_valid  in   1  code from the OTA core is valid
//  in_data   in   W  signed code
//  in_ready  out  1  stage can accept a code
//  out_up    out  1  source pulse (positive code)
//  out_dn    out  1  sink pulse (negative code)
//  busy      out  1  a code is currently being applied (state RUN)
//  underrun  out  1  sticky: a hold window expired with no next code
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all outputs 0; cur/nxt registers cleared; acc=0; state IDLE.
//    Reset during RUN aborts the window immediately.
//  - Double buffer: cur (applied code) and nxt (one-entry skid).
//    in_ready = ena & !nxt_full. A transfer happens on a cycle with in_valid & in_ready.
//  - States: IDLE -> RUN on nxt_full. Entering RUN loads nxt into cur, clears nxt_full,
//    sets hold_cnt = HOLD_CYC-1, and clears acc.
//    In RUN, hold_cnt decrements each enabled cycle. At hold_cnt==0:
//      nxt_full = 1: reload cur, hold_cnt = HOLD_CYC-1 (back-to-back, no gap).
//      nxt_full = 0: go to IDLE and set underrun.
//  - Simultaneous transfer and reload in the same cycle: nxt takes the new code.
//    The old nxt value moves to cur. Nothing is lost.
//  - underrun clears only on reset or on the next transfer. The transfer wins over
//    setting, so a transfer arriving on the expiry cycle leaves underrun = 0.
//  - Magnitude: mag = |cur|, with -2^(W-1) saturated to 2^(W-1)-1. Width W-1 bits, unsigned.
//  - Modulator: acc is W-1 bits; {carry, acc} <= acc + mag every RUN cycle.
//    When carry = 1, the cycle's pulse goes to out_up if cur >= 0, else to out_dn.
//    Pulses are registered, so there is 1 cycle of latency from the carry to the pin.
//    A code of 0 produces no pulses. Over one window, pulse count = floor(HOLD_CYC*mag / 2^(W-1)) ±1.
//  - out_up & out_dn are never 1 in the same cycle. Both are 0 in IDLE.
//  - ena = 0: all state is frozen, in_ready = 0, and out_up/out_dn are forced to 0.
//    busy and underrun hold their values.
// CONFIGURATION
//  OTA_DEADTIME_EN defined:
//    - A pulse in the opposite direction to the last emitted pulse starts a dead timer of DEAD_CYC cycles.
//    - While the timer is nonzero, carries still advance acc, but their pulses are dropped.
//    - The timer decrements in RUN only; the last direction is kept across IDLE.
//  OTA_DEADTIME_EN undefined:
//    - Direction changes take effect on the next pulse. No timer logic is present.
// STRUCTURE
//  - Package ota_pkg: localparams W_DEF=8, HOLD_DEF=16; typedef enum {IDLE, RUN} ota_out_state_t;
//    function sat_abs().
//  - Sub-module ota_skid1: the one-entry nxt buffer with its valid/ready logic.
//  - Counter, accumulator and FSM stay in this module.
// TESTING
//  T1 reset: hold rst_n=0 for 3 clks while in_valid=1 -> in_ready, out_up, out_dn, busy, underrun
//     are all 0 one clk later.
//  T2 code +64, HOLD_CYC=16:
//     - 8 out_up pulses over the window, in alternating cycles; out_dn stays 0.
//     - underrun is set after the window.
//  T3 code -128: saturates to mag 127; 15 or 16 out_dn pulses per window; out_up stays 0.
//  T4 back-to-back stream +32, -32, 0 with in_valid held at 1:
//     - busy stays 1 with no gap; pulse counts per window are 4 up, 4 down, 0.
//     - underrun rises only after the third window.
//  T5 with OTA_DEADTIME_EN defined, +127 followed by -127:
//     - The first 2 out_dn carries after the change are dropped.
//     - No cycle has out_up & out_dn both high.
//  T6 ena low for 5 clks mid-window:
//     - Pins are 0 and hold_cnt/acc are unchanged.
//     - After ena returns, the window finishes with the same total pulse count as an
//       uninterrupted run.

Source files
------------

// File: rtl/ota_pkg.sv
// -----------------------------------------------------------------------------
// ota_pkg
//   Shared definitions for the OTA pulse-density output stage: default widths,
//   the output FSM state type and the saturating magnitude helper.
//   Optional build macro used by the stage: OTA_DEADTIME_EN.
// -----------------------------------------------------------------------------
package ota_pkg;

   localparam int W_DEF    = 8;
   localparam int HOLD_DEF = 16;
   localparam int DEAD_DEF = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ota_out_state_t;

   // |v| for a sign-extended w-bit code, with the most negative code clipped
   // to the largest positive magnitude so the result always fits in w-1 bits.
   function automatic logic [31:0] sat_abs(input logic [31:0] v_sx,
                                           input int unsigned w);
      logic [31:0] mag;
      logic [31:0] lim;
      lim = (32'd1 << (w - 32'd1)) - 32'd1;
      if (v_sx[31]) begin
         mag = 32'd0 - v_sx;
      end else begin
         mag = v_sx;
      end
      if (mag > lim) begin
         mag = lim;
      end else begin
         mag = mag;
      end
      return mag;
   endfunction

endpackage

// File: rtl/ota_skid1.sv
// -----------------------------------------------------------------------------
// ota_skid1
//   One-entry "next code" buffer in front of the applied code register.
//   Accepts a code whenever it is empty and the stage is enabled; the FSM
//   empties it with pop when it moves the code into the applied register.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   ena          enable; low freezes the buffer and deasserts in_ready
//   in_valid     upstream code valid
//   in_data      upstream code (W bits)
//   pop          FSM consumes the buffered code this cycle
//   in_ready     buffer can accept a code
//   xfer         a code is accepted this cycle
//   nxt_full     buffer holds a code
//   nxt_data     buffered code
// -----------------------------------------------------------------------------
module ota_skid1
   import ota_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         pop,
   output logic         in_ready,
   output logic         xfer,
   output logic         nxt_full,
   output logic [W-1:0] nxt_data
);

   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;

   // Ready is also gated by rst_n so nothing is offered while reset is held.
   assign in_ready = ena & rst_n & ~full_q;
   assign xfer     = in_valid & in_ready;
   assign nxt_full = full_q;
   assign nxt_data = data_q;

   // Next-state of the buffer: a new code wins over a simultaneous pop.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (!ena) begin
         full_d = full_q;
      end else if (xfer) begin
         full_d = 1'b1;
         data_d = in_data;
      end else if (pop) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
   end

   // Buffer registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/ota_pdm_out.sv
// -----------------------------------------------------------------------------
// ota_pdm_out
//   Output stage behind the digital OTA core. Each accepted signed code is
//   applied for HOLD_CYC clocks; during that window a first-order accumulator
//   turns |code| into a pulse-density stream on out_up (code >= 0) or out_dn
//   (code < 0). A one-entry buffer allows back-to-back windows with no gap.
//   Optional macro OTA_DEADTIME_EN: drop pulses for DEAD_CYC cycles after a
//   change of pulse direction.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   ena          enable; low freezes all state and forces the pins low
//   in_valid     code valid from the OTA core
//   in_data      signed code
//   in_ready     stage can accept a code
//   out_up       source pulse
//   out_dn       sink pulse
//   busy         a code is being applied
//   underrun     sticky: a window ended with no code waiting
// Notes
//   Pulses are registered, so the pulse of the last window cycle appears on
//   the pin in the following cycle.
// -----------------------------------------------------------------------------
module ota_pdm_out
   import ota_pkg::*;
#(
   parameter int W        = W_DEF,
   parameter int HOLD_CYC = HOLD_DEF,
   parameter int DEAD_CYC = DEAD_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_up,
   output logic         out_dn,
   output logic         busy,
   output logic         underrun
);

   localparam int HC_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

   ota_out_state_t  state_q, state_d;
   logic [W-1:0]    cur_q, cur_d;
   logic [HC_W-1:0] hold_q, hold_d;
   logic [W-2:0]    acc_q, acc_d;
   logic            up_q, up_d;
   logic            dn_q, dn_d;
   logic            underrun_q, underrun_d;

   logic            xfer_s;
   logic            pop_s;
   logic            nxt_full_s;
   logic [W-1:0]    nxt_data_s;
   logic [31:0]     mag_full_s;
   logic [W-2:0]    mag_s;
   logic [W-1:0]    sum_s;
   logic            carry_s;
   logic            dir_dn_s;
   logic            drop_s;
   logic            unused_mag_s;

`ifdef OTA_DEADTIME_EN
   localparam int DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC + 1) : 1;
   logic [DC_W-1:0] dead_q, dead_d;
   logic            last_dn_q, last_dn_d;
`endif

   ota_skid1 #(.W(W)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .in_valid (in_valid),
      .in_data  (in_data),
      .pop      (pop_s),
      .in_ready (in_ready),
      .xfer     (xfer_s),
      .nxt_full (nxt_full_s),
      .nxt_data (nxt_data_s)
   );

   assign mag_full_s   = sat_abs({{(32-W){cur_q[W-1]}}, cur_q}, W);
   assign mag_s        = mag_full_s[W-2:0];
   assign unused_mag_s = ^mag_full_s[31:W-1];
   assign sum_s        = {1'b0, acc_q} + {1'b0, mag_s};
   assign carry_s      = sum_s[W-1];
   assign dir_dn_s     = cur_q[W-1];

`ifdef OTA_DEADTIME_EN
   // Dead-time tracking: a carry opposite to the last direction opens a
   // DEAD_CYC-cycle window (including the triggering cycle) of dropped pulses.
   always_comb begin
      dead_d    = dead_q;
      last_dn_d = last_dn_q;
      drop_s    = 1'b0;
      if (ena && (state_q == RUN)) begin
         if (carry_s && (dir_dn_s != last_dn_q)) begin
            dead_d    = DC_W'(DEAD_CYC - 1);
            last_dn_d = dir_dn_s;
            drop_s    = 1'b1;
         end else if (dead_q != '0) begin
            dead_d = dead_q - DC_W'(1);
            drop_s = 1'b1;
         end else begin
            drop_s = 1'b0;
         end
      end else begin
         drop_s = 1'b0;
      end
   end

   // Dead-time registers; the last direction survives IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dead_q    <= '0;
         last_dn_q <= 1'b0;
      end else begin
         dead_q    <= dead_d;
         last_dn_q <= last_dn_d;
      end
   end
`else
   assign drop_s = 1'b0;
`endif

   // FSM, hold counter, accumulator and pulse generation.
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      hold_d     = hold_q;
      acc_d      = acc_q;
      up_d       = up_q;
      dn_d       = dn_q;
      underrun_d = underrun_q;
      pop_s      = 1'b0;
      if (ena) begin
         case (state_q)
            IDLE: begin
               up_d = 1'b0;
               dn_d = 1'b0;
               if (nxt_full_s) begin
                  state_d = RUN;
                  cur_d   = nxt_data_s;
                  pop_s   = 1'b1;
                  hold_d  = HC_W'(HOLD_CYC - 1);
                  acc_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               acc_d = sum_s[W-2:0];
               up_d  = carry_s & ~drop_s & ~dir_dn_s;
               dn_d  = carry_s & ~drop_s &  dir_dn_s;
               if (hold_q == '0) begin
                  if (nxt_full_s) begin
                     // Back-to-back: accumulator phase carries into the next code.
                     cur_d  = nxt_data_s;
                     pop_s  = 1'b1;
                     hold_d = HC_W'(HOLD_CYC - 1);
                  end else begin
                     state_d    = IDLE;
                     underrun_d = 1'b1;
                  end
               end else begin
                  hold_d = hold_q - HC_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               up_d    = 1'b0;
               dn_d    = 1'b0;
            end
         endcase
         // A fresh code clears underrun, even on the expiry cycle.
         if (xfer_s) begin
            underrun_d = 1'b0;
         end else begin
            underrun_d = underrun_d;
         end
      end else begin
         pop_s = 1'b0;
      end
   end

   // Stage registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         hold_q     <= '0;
         acc_q      <= '0;
         up_q       <= 1'b0;
         dn_q       <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         hold_q     <= hold_d;
         acc_q      <= acc_d;
         up_q       <= up_d;
         dn_q       <= dn_d;
         underrun_q <= underrun_d;
      end
   end

   // A pulse held across a freeze reappears once ena returns, so none is lost.
   assign out_up   = up_q & ena;
   assign out_dn   = dn_q & ena;
   assign busy     = (state_q == RUN);
   assign underrun = underrun_q;

endmodule
